md_sched: RTL
=============

# md_sched

Multiply/divide scheduler for the five-stage pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from EX and holds the operation busy for a fixed latency. It owns the HI/LO registers and raises a stall request so that a HI/LO-class instruction in ID waits until the result is committed. It sits beside the ALU in EX; the hazard logic ORs `stall_req` into the PC/IF_ID stall and the ID_EX clear.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU, must be ≥1.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU, must be ≥1.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `start`  in  1  EX holds a valid md-class instruction this cycle.
- `op`  in  3  operation code from the shared package: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- `data_rs`  in  32  forwarded rs value in EX.
- `data_rt`  in  32  forwarded rt value in EX.
- `md_use_id`  in  1  ID instruction is md-class (MFHI/MFLO/MTHI/MTLO/MULT*/DIV*).
- `busy`  out  1  multi-cycle operation in flight.
- `stall_req`  out  1  stall IF/ID, bubble into EX.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, RUN. Reset forces IDLE, `busy`=0, `hi`=`lo`=0, counter=0, pending result cleared.
- IDLE, `start`, op ∈ {MULT, MULTU, DIV, DIVU}: latch the 64-bit result computed from `data_rs`/`data_rt`, load the counter with N−1 (N = MULT_CYCLES or DIV_CYCLES), go to RUN.
- RUN: decrement the counter each cycle. At counter=0, commit the pending result to `hi`/`lo` and return to IDLE on the same edge.
- MULT: {hi,lo} = signed rs×rt. MULTU: unsigned. DIV: lo = quotient, hi = remainder, truncating toward zero, remainder takes the sign of the dividend. DIVU: unsigned.
- Divide by zero (DIV/DIVU): lo = 0xFFFFFFFF, hi = rs. Signed overflow 0x80000000 / −1: lo = 0x80000000, hi = 0.
- MTHI/MTLO in IDLE: write rs to hi/lo at the edge ending the `start` cycle. No RUN entry, `busy` stays 0.
- `start` while in RUN is ignored; the hazard logic guarantees it cannot occur. The bench checks that HI/LO and the counter stay unaffected.
- `stall_req` = `md_use_id` & (`busy` | (`start` & op is mult/div)). It is combinational.
- `busy` is registered and equals (state == RUN).

## Timing
- `start` of mult/div sampled at edge t: `busy`=1 for exactly N cycles (from after edge t to edge t+N). New `hi`/`lo` are visible after edge t+N, and `busy` falls on that same edge.
- An md-class instruction in ID during the `start` cycle or any RUN cycle is stalled. It reaches EX no earlier than the cycle after `busy` falls, so it reads committed HI/LO.
- MTHI/MTLO: one-cycle latency, with no stall generated for a following MFHI/MFLO.
- Asynchronous reset mid-RUN aborts the operation. Outputs reach their reset values immediately, independent of `clk`, and the pending result is discarded.
- HI/LO are never partially updated: both halves commit on the same edge.

## Structure
- Shared package (`instructions.v` defines): op encodings MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5, plus the width constant `WIDTH_MDOP`=3.
- Single module with no sub-module. The counter, FSM, and result computation are inline. The result is computed combinationally at `start` and held in a 64-bit pending register.
- The Decoder maps its instruction enum to `op`/`md_use_id`; that mapping lives outside this block.

## Test plan
- MULT rs=0xFFFFFFFE (−2), rt=3, default params → `busy` high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=−7, rt=2 → `busy` for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=0 → lo=0xFFFFFFFF, hi=7.
- MTHI rs=0x12345678, then MFHI in ID the next cycle → `stall_req`=0 throughout, hi=0x12345678 one cycle after `start`.
- MULT followed back-to-back by MFLO in ID → `stall_req`=1 for the `start` cycle plus 5 busy cycles, dropping to 0 in the cycle after `busy` falls.
- Assert `reset`=0 at the third RUN cycle of DIV → `busy`=0 and hi=lo=0 immediately. After release, no late commit occurs.
- Inject `start` with DIV during RUN of a MULT → ignored; the MULT result commits on schedule and `busy` falls after 5 cycles.

Source files
------------

// File: rtl/md_sched_pkg.sv
// Shared multiply/divide definitions: op encodings, FSM states, op-class helper.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package md_sched_pkg;

    localparam int WIDTH_MDOP = 3;

    // Operation codes driven by the decoder into the md scheduler
    typedef enum logic [WIDTH_MDOP-1:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } mdOp_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdState_e;

    // True for the ops that occupy the unit for multiple cycles
    function automatic logic isMulDiv(input logic [WIDTH_MDOP-1:0] opCode);
        return (opCode == MD_MULT) || (opCode == MD_MULTU) ||
               (opCode == MD_DIV)  || (opCode == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_sched.sv
// Multiply/divide scheduler: owns HI/LO, holds mult/div busy for a fixed cycle count.
// Latency: MULT* commit MULT_CYCLES edges after start, DIV* DIV_CYCLES edges; MTHI/MTLO one edge.
// Backpressure: no handshake; stall_req holds an md-class ID instruction while busy or a mult/div starts.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH_MDOP-1:0] op,
    input  logic [31:0]           data_rs,
    input  logic [31:0]           data_rt,
    input  logic                  md_use_id,
    output logic                  busy,
    output logic                  stall_req,
    output logic [31:0]           hi,
    output logic [31:0]           lo
);

    // Counter only ever holds N-1, so it is sized for the larger latency minus one
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    mdState_e          state;
    logic [CNT_W-1:0]  cnt;
    logic [63:0]       pending;
    logic [63:0]       mdResult;

    logic signed [63:0] rsSext, rtSext, mulS;
    logic        [63:0] mulU;
    logic               rtZero, sOvf;
    logic signed [31:0] divA, divB, sQuot, sRem;
    logic        [31:0] uDivB, uQuot, uRem;

    // Products: operands widened to 64 bits so the low 64 bits of the product are exact
    assign rsSext = {{32{data_rs[31]}}, data_rs};
    assign rtSext = {{32{data_rt[31]}}, data_rt};
    assign mulS   = rsSext * rtSext;
    assign mulU   = {32'd0, data_rs} * {32'd0, data_rt};

    // Divides: forcing the divisor to 1 on zero or 0x80000000/-1 keeps the divider
    // defined; with divisor 1 the overflow case naturally yields q=0x80000000, r=0
    assign rtZero = (data_rt == 32'd0);
    assign sOvf   = (data_rs == 32'h8000_0000) && (data_rt == 32'hFFFF_FFFF);
    assign divA   = $signed(data_rs);
    assign divB   = (rtZero || sOvf) ? 32'sd1 : $signed(data_rt);
    assign sQuot  = divA / divB;
    assign sRem   = divA % divB;
    assign uDivB  = rtZero ? 32'd1 : data_rt;
    assign uQuot  = data_rs / uDivB;
    assign uRem   = data_rs % uDivB;

    // Select the {hi,lo} result for the op presented in EX
    always_comb begin
        mdResult = '0;
        case (op)
            MD_MULT:  mdResult = mulS;
            MD_MULTU: mdResult = mulU;
            MD_DIV:   mdResult = rtZero ? {data_rs, 32'hFFFF_FFFF} : {sRem, sQuot};
            MD_DIVU:  mdResult = rtZero ? {data_rs, 32'hFFFF_FFFF} : {uRem, uQuot};
            default:  mdResult = '0;
        endcase
    end

    // FSM: latch result and count down in RUN, commit both halves together on the last edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            pending <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            MD_MULT, MD_MULTU: begin
                                pending <= mdResult;
                                cnt     <= MULT_LOAD;
                                state   <= ST_RUN;
                                busy    <= 1'b1;
                            end
                            MD_DIV, MD_DIVU: begin
                                pending <= mdResult;
                                cnt     <= DIV_LOAD;
                                state   <= ST_RUN;
                                busy    <= 1'b1;
                            end
                            MD_MTHI: hi <= data_rs;
                            MD_MTLO: lo <= data_rs;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    // start is ignored here; hazard logic keeps md instructions out of EX
                    if (cnt == '0) begin
                        hi    <= pending[63:32];
                        lo    <= pending[31:0];
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Hold an md-class ID instruction while an op is in flight or about to launch
    assign stall_req = md_use_id & (busy | (start & isMulDiv(op)));

endmodule
